// File: rtl/ldq_alloc_ctrl_pkg.sv
// Shared load-queue definitions: age tag type and age-compare helpers.
// The load-store disambiguation logic uses the same tag type.
package ldq_alloc_ctrl_pkg;

  localparam int LDQ_INDEX = 4;
  localparam int LDQ_DEPTH = 2 ** LDQ_INDEX;
  localparam int LDQ_WIDTH = 8;

  // Age tag: wrap bit on top of the entry index.
  typedef logic [LDQ_INDEX:0] ldq_tag_t;

  // Distance of tag from base in allocation order, modulo the tag space.
  function automatic ldq_tag_t ldq_age_dist(input ldq_tag_t tag, input ldq_tag_t base);
    return ldq_tag_t'(tag - base);
  endfunction

  // True when a is strictly older than b, both measured from the same head.
  function automatic logic ldq_is_older(input ldq_tag_t a, input ldq_tag_t b,
                                        input ldq_tag_t head);
    return ldq_age_dist(a, head) < ldq_age_dist(b, head);
  endfunction

endpackage

// File: rtl/ldq_wrap_ptr.sv
// Wrap-bit pointer register. Load has priority over increment; the natural
// INDEX+1 bit add rolls the index and toggles the wrap bit together.
module ldq_wrap_ptr #(
  parameter int INDEX = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [INDEX:0]   load_val_i,
  output logic [INDEX:0]   ptr_o
);

  localparam logic [INDEX:0] PTR_ONE = {{INDEX{1'b0}}, 1'b1};

  logic [INDEX:0] ptr_q;

  // Pointer register: load, else increment, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (load_i) begin
      ptr_q <= load_val_i;
    end else if (inc_i) begin
      ptr_q <= ptr_q + PTR_ONE;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ldq_alloc_ctrl.sv
// Load-queue allocation/retirement controller. Drives the storage RAM write
// port on allocation, pops the head on commit, restores the tail on flush,
// and keeps a sticky protocol-error flag.
module ldq_alloc_ctrl
  import ldq_alloc_ctrl_pkg::*;
#(
  parameter int DEPTH = LDQ_DEPTH,
  parameter int INDEX = LDQ_INDEX,
  parameter int WIDTH = LDQ_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               alloc_valid_i,
  input  logic [WIDTH-1:0]   alloc_data_i,
  output logic               alloc_ready_o,
  output logic [INDEX:0]     alloc_id_o,
  input  logic               commit_i,
  input  logic               flush_i,
  input  logic [INDEX:0]     flush_tail_i,
  output logic               ram_we_o,
  output logic [INDEX-1:0]   ram_addr_wr_o,
  output logic [WIDTH-1:0]   ram_data_wr_o,
  output logic [INDEX-1:0]   ram_head_addr_o,
  input  logic [WIDTH-1:0]   ram_head_data_i,
  output logic               head_valid_o,
  output logic [WIDTH-1:0]   head_data_o,
  output logic [INDEX:0]     count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               err_o
);

  localparam logic [INDEX:0] DEPTH_TAG = DEPTH[INDEX:0];

  logic [INDEX:0] head;
  logic [INDEX:0] tail;
  logic [INDEX:0] head_next;
  logic [INDEX:0] count;
  logic [INDEX:0] flush_dist;
  logic [INDEX:0] tail_dist;
  logic           empty;
  logic           full;
  logic           alloc_fire;
  logic           commit_fire;
  logic           flush_legal;
  logic           tail_load;
  logic           err_set;
  logic           err_q;

  // Occupancy and status; count wraps naturally in the tag space.
  always_comb begin
    count = tail - head;
    empty = (head == tail);
    full  = (count == DEPTH_TAG);
  end

  // Handshake, commit qualification and flush legality. The flush window is
  // measured from the head as it will be after this cycle's commit.
  always_comb begin
    alloc_ready_o = !full && !flush_i;
    alloc_fire    = alloc_valid_i && alloc_ready_o;
    commit_fire   = commit_i && !empty;
    head_next     = head + {{INDEX{1'b0}}, commit_fire};
    flush_dist    = flush_tail_i - head_next;
    tail_dist     = tail - head_next;
    flush_legal   = (flush_dist <= tail_dist);
    tail_load     = flush_i && flush_legal;
    err_set       = (commit_i && empty) || (flush_i && !flush_legal);
  end

  ldq_wrap_ptr #(.INDEX(INDEX)) u_head_ptr (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (commit_fire),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (head)
  );

  // Allocation and flush are exclusive because a flush drops ready.
  ldq_wrap_ptr #(.INDEX(INDEX)) u_tail_ptr (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (alloc_fire),
    .load_i     (tail_load),
    .load_val_i (flush_tail_i),
    .ptr_o      (tail)
  );

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  // Output drive: RAM write port, head read path and status.
  always_comb begin
    ram_we_o        = alloc_fire;
    ram_addr_wr_o   = tail[INDEX-1:0];
    ram_data_wr_o   = alloc_data_i;
    alloc_id_o      = tail;
    ram_head_addr_o = head[INDEX-1:0];
    head_data_o     = ram_head_data_i;
    head_valid_o    = !empty;
    count_o         = count;
    full_o          = full;
    empty_o         = empty;
    err_o           = err_q;
  end

endmodule

// File: doc/ldq_alloc_ctrl.md
# ldq_alloc_ctrl

Allocation and retirement controller for the load queue. It sits directly upstream of the load-queue storage RAM, which has a single write port and two read ports. The block accepts in-order load allocations from dispatch and drives the RAM write port, hands out age-tagged queue IDs, and pops the head on commit. It also restores the tail on branch/exception recovery and feeds the head entry back to retire.

## Interface
Parameters:
- DEPTH, 16: queue entries; must equal 2**INDEX.
- INDEX, 4: entry index width.
- WIDTH, 8: entry payload width; matches the storage RAM.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid_i  in  1  dispatch presents a load.
- alloc_data_i  in  WIDTH  payload for the new entry.
- alloc_ready_o  out  1  allocation accepted this cycle when high together with alloc_valid_i.
- alloc_id_o  out  INDEX+1  age tag (wrap bit, index) of the entry being allocated, equal to the current tail.
- commit_i  in  1  retire the head entry.
- flush_i  in  1  recovery: squash every entry at or younger than flush_tail_i.
- flush_tail_i  in  INDEX+1  new tail age tag.
- ram_we_o  out  1  to RAM we0_i.
- ram_addr_wr_o  out  INDEX  to RAM addr0wr_i.
- ram_data_wr_o  out  WIDTH  to RAM data0wr_i.
- ram_head_addr_o  out  INDEX  to RAM addr0_i.
- ram_head_data_i  in  WIDTH  from RAM data0_o (combinational read).
- head_valid_o  out  1  head entry exists.
- head_data_o  out  WIDTH  head payload.
- count_o  out  INDEX+1  occupancy, 0..DEPTH.
- full_o / empty_o  out  1 each  occupancy == DEPTH / == 0.
- err_o  out  1  sticky protocol-error flag.

## Operation
- State: head and tail pointers, each INDEX+1 bits (wrap bit plus index), and a sticky err bit. Nothing else.
- count = tail - head, computed modulo 2**(INDEX+1). empty = (head == tail). full = index fields equal and wrap bits differ.
- Ready: alloc_ready_o = !full_o && !flush_i. It never depends on commit_i, so a same-cycle commit does not allow allocation into a full queue.
- Allocate (alloc_valid_i && alloc_ready_o):
  - ram_we_o=1, ram_addr_wr_o=tail[INDEX-1:0], ram_data_wr_o=alloc_data_i, all combinational in the same cycle.
  - tail increments on the clock edge.
  - ram_we_o is 0 whenever no allocation is accepted.
- Commit (commit_i && !empty_o): head increments.
  - commit_i while empty is ignored and sets err.
- Flush (flush_i): tail <= flush_tail_i. Any allocation attempt that cycle is dropped, because ready is low.
  - A same-cycle commit is still applied.
  - Legal flush_tail_i lies in [new head, old tail] by age. Anything else sets err and leaves tail unchanged.
- Head read path:
  - ram_head_addr_o = head[INDEX-1:0].
  - head_data_o = ram_head_data_i.
  - head_valid_o = !empty_o.
- Wrap-around: index fields roll from DEPTH-1 to 0 and the wrap bit toggles. No entry is skipped.
- err_o is cleared only by reset.

## Timing
- Reset values: head=tail=0, count_o=0, empty_o=1, full_o=0, alloc_ready_o=1, alloc_id_o=0, head_valid_o=0, ram_we_o=0, err_o=0.
- Allocation latency: the entry is written at the edge ending the accept cycle. count_o, empty_o and head_valid_o reflect it in the next cycle. head_data_o for an entry allocated into an empty queue is valid in that next cycle.
- Allocate and commit in the same cycle (queue neither empty nor full): count is unchanged and both pointers advance.
- Allocate and commit in the same cycle with the queue empty: the allocation is accepted and the commit is ignored with err set.
- A flush takes effect at the next edge. alloc_id_o in the following cycle equals flush_tail_i.
- flush_tail_i == head (all entries squashed) gives count 0 and empty next cycle.
- Reset asserted mid-operation clears all state asynchronously; outputs take reset values immediately. RAM contents are not cleared; the queue treats them as stale.

## Structure
- The ldq tag typedef (INDEX+1-bit age tag) and the age-compare helper belong in the shared core package. Load-store disambiguation uses the same tag.
- One natural sub-module: ldq_wrap_ptr, a wrap-bit pointer register with increment and load. It is instantiated twice, for head and tail.
- The load-queue storage RAM is instantiated by the parent, not inside this block.

## Test plan
- Reset, then 16 allocations with data 0x10..0x1F: alloc_id_o steps 0x00..0x0F; full_o=1 and alloc_ready_o=0 after the 16th; a 17th request is not written (ram_we_o=0).
- 16 commits: head_data_o reads 0x10..0x1F in order; empty_o=1 afterwards.
- Wrap: 20 interleaved allocate/commit pairs: ids wrap from 0x0F to 0x10 (wrap bit set); count_o holds at 1 throughout.
- Allocate 8 (ids 0..7), then flush with flush_tail_i=3: count_o=3 next cycle, and the next allocation gets id 3 and writes RAM address 3.
- Full queue with commit_i and alloc_valid_i in the same cycle: commit accepted, allocation rejected, count_o=15.
- commit_i on an empty queue, and a flush with flush_tail_i older than head: err_o=1 and stays set; pointers unchanged; an asynchronous reset pulse clears everything, including err_o.
